check_node_unit: RTL and testbench

Serial min-sum Check Node Unit (CNU) for the LDPC decoder. It is the counterpart of the VNU on the CNU↔VNU message interface. It accepts DEG 6-bit variable-to-check messages one per handshake, in VNU output format {hard_decision, sign, 4-bit magnitude}. It then returns DEG 5-bit sign-magnitude check-to-variable messages {sign, 4-bit magnitude} in the same edge order, which is the VNU input format. It also reports the parity of the received hard decisions for the syndrome check.

---
 rtl/ldpc_pkg.sv | 11 +
 rtl/check_node_unit_if.sv | 17 +
 rtl/cnu_min_tracker.sv | 25 ++
 rtl/check_node_unit.sv | 112 +++++++++++
 tb/tb_check_node_unit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: decoder-wide message widths, bit positions and shared types for the VNU and CNU
package ldpc_pkg;
    localparam int MAG_W    = 4;
    localparam int MAG_MAX  = 15;
    localparam int V2C_W    = 6;
    localparam int C2V_W    = 5;
    localparam int HD_BIT   = 5;
    localparam int SIGN_BIT = 4;
    typedef logic [MAG_W-1:0] mag_t;
    typedef enum logic {COLLECT, EMIT} cnu_state_t;
endpackage

// File: rtl/check_node_unit_if.sv
// check_node_unit_if: CNU message bus; master = upstream/downstream driver, slave = CNU
// Signals: in_valid/in_ready/in_msg (v2c input), out_valid/out_ready/out_msg/out_last (c2v output), parity_ok
interface check_node_unit_if;
    import ldpc_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [V2C_W-1:0] in_msg;
    logic             out_valid;
    logic             out_ready;
    logic [C2V_W-1:0] out_msg;
    logic             out_last;
    logic             parity_ok;
    modport master (output in_valid, in_msg, out_ready,
                    input  in_ready, out_valid, out_msg, out_last, parity_ok);
    modport slave  (input  in_valid, in_msg, out_ready,
                    output in_ready, out_valid, out_msg, out_last, parity_ok);
endinterface

// File: rtl/cnu_min_tracker.sv
// cnu_min_tracker: combinational two-minimum/index update for one incoming magnitude
// Ports: m (new magnitude), k (its edge index), min1/min2/idx1 (current), *_n (updated)
module cnu_min_tracker
    import ldpc_pkg::*;
#(
    parameter int KW = 3
) (
    input  mag_t          m,
    input  logic [KW-1:0] k,
    input  mag_t          min1,
    input  mag_t          min2,
    input  logic [KW-1:0] idx1,
    output mag_t          min1_n,
    output mag_t          min2_n,
    output logic [KW-1:0] idx1_n
);
    // strict compares: ties keep the earlier index and a repeated minimum lands in min2
    logic lt1;
    always_comb begin
        lt1    = m < min1;
        min1_n = lt1 ? m : min1;
        min2_n = lt1 ? min1 : (m < min2 ? m : min2);
        idx1_n = lt1 ? k : idx1;
    end
endmodule

// File: rtl/check_node_unit.sv
// check_node_unit: serial offset-min-sum check node, collects DEG v2c messages then emits DEG c2v messages
// Ports: clk, rst (async active-high), bus (check_node_unit_if.slave)
module check_node_unit
    import ldpc_pkg::*;
#(
    parameter int DEG    = 6,
    parameter int OFFSET = 0
) (
    input logic               clk,
    input logic               rst,
    check_node_unit_if.slave  bus
);
    localparam int            KW     = $clog2(DEG);
    localparam logic [KW-1:0] K_LAST = KW'(DEG - 1);
    localparam mag_t          OFF    = MAG_W'(OFFSET);
    localparam mag_t          MAXM   = MAG_W'(MAG_MAX);

    cnu_state_t     state_q, state_d;
    logic [KW-1:0]  k_q, k_d, idx1_q, idx1_d, idx1_n;
    mag_t           min1_q, min1_d, min2_q, min2_d, min1_n, min2_n;
    logic [DEG-1:0] sgn_q, sgn_d;
    logic           sign_xor_q, sign_xor_d, hd_xor_q, hd_xor_d, parity_q, parity_d;
    mag_t           sel_mag, out_mag;
    logic           emit;

    cnu_min_tracker #(.KW(KW)) u_trk (
        .m      (bus.in_msg[MAG_W-1:0]),
        .k      (k_q),
        .min1   (min1_q),
        .min2   (min2_q),
        .idx1   (idx1_q),
        .min1_n (min1_n),
        .min2_n (min2_n),
        .idx1_n (idx1_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            k_q        <= '0;
            idx1_q     <= '0;
            min1_q     <= MAXM;
            min2_q     <= MAXM;
            sgn_q      <= '0;
            sign_xor_q <= 1'b0;
            hd_xor_q   <= 1'b0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            idx1_q     <= idx1_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            sgn_q      <= sgn_d;
            sign_xor_q <= sign_xor_d;
            hd_xor_q   <= hd_xor_d;
            parity_q   <= parity_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        idx1_d     = idx1_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        sgn_d      = sgn_q;
        sign_xor_d = sign_xor_q;
        hd_xor_d   = hd_xor_q;
        parity_d   = parity_q;
        if (state_q == COLLECT) begin
            if (bus.in_valid) begin
                sgn_d[k_q] = bus.in_msg[SIGN_BIT];
                sign_xor_d = sign_xor_q ^ bus.in_msg[SIGN_BIT];
                hd_xor_d   = hd_xor_q ^ bus.in_msg[HD_BIT];
                min1_d     = min1_n;
                min2_d     = min2_n;
                idx1_d     = idx1_n;
                k_d        = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    parity_d = ~(hd_xor_q ^ bus.in_msg[HD_BIT]);
                    k_d      = '0;
                    state_d  = EMIT;
                end
            end
        end else if (bus.out_ready) begin
            k_d = k_q + 1'b1;
            if (k_q == K_LAST) begin
                k_d        = '0;
                idx1_d     = '0;
                min1_d     = MAXM;
                min2_d     = MAXM;
                sign_xor_d = 1'b0;
                hd_xor_d   = 1'b0;
                state_d    = COLLECT;
            end
        end
    end

    // each edge gets the minimum over the other edges; the offset saturates at zero
    always_comb begin
        emit    = state_q == EMIT;
        sel_mag = (k_q == idx1_q) ? min2_q : min1_q;
        out_mag = (sel_mag > OFF) ? sel_mag - OFF : '0;
    end

    assign bus.in_ready  = !emit;
    assign bus.out_valid = emit;
    assign bus.out_msg   = emit ? {sign_xor_q ^ sgn_q[k_q], out_mag} : '0;
    assign bus.out_last  = emit && (k_q == K_LAST);
    assign bus.parity_ok = parity_q;
endmodule

// File: tb/tb_check_node_unit.sv
// tb_check_node_unit: directed + random frames through OFFSET=0 and OFFSET=2 CNUs against an exclusion min-sum model
module tb_check_node_unit;
    import ldpc_pkg::*;
    localparam int DEG = 6;
    typedef int arr_t [DEG];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    check_node_unit_if if0 ();
    check_node_unit_if if2 ();

    check_node_unit #(.DEG(DEG), .OFFSET(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    check_node_unit #(.DEG(DEG), .OFFSET(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int checks = 0;
    int errors = 0;
    logic [5:0] msg [DEG];
    logic exp_par = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] m, input logic r);
        if0.in_valid = v; if2.in_valid = v;
        if0.in_msg = m;   if2.in_msg = m;
        if0.out_ready = r; if2.out_ready = r;
    endtask

    // output k of a min-sum check node = min/sign-product over every other edge
    function automatic logic [4:0] exp_out(input int k, input int off);
        int mn = 16;
        logic s = 1'b0;
        for (int j = 0; j < DEG; j++)
            if (j != k) begin
                if (int'(msg[j][3:0]) < mn) mn = int'(msg[j][3:0]);
                s ^= msg[j][4];
            end
        mn = (mn > off) ? mn - off : 0;
        return {s, 4'(mn)};
    endfunction

    task automatic load(input arr_t mg, input arr_t sg, input arr_t hd);
        for (int i = 0; i < DEG; i++) msg[i] = {hd[i][0], sg[i][0], 4'(mg[i])};
    endtask

    task automatic load_rand();
        for (int i = 0; i < DEG; i++) msg[i] = 6'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid0"}, 8'(if0.out_valid), 8'd0);
        chk({tag, "_valid2"}, 8'(if2.out_valid), 8'd0);
        chk({tag, "_ready0"}, 8'(if0.in_ready), 8'd1);
        chk({tag, "_ready2"}, 8'(if2.in_ready), 8'd1);
        chk({tag, "_par0"}, 8'(if0.parity_ok), 8'(exp_par));
        chk({tag, "_par2"}, 8'(if2.parity_ok), 8'(exp_par));
    endtask

    task automatic check_out(input int k);
        chk("out_valid0", 8'(if0.out_valid), 8'd1);
        chk("out_valid2", 8'(if2.out_valid), 8'd1);
        chk($sformatf("out_msg0_k%0d", k), 8'(if0.out_msg), 8'(exp_out(k, 0)));
        chk($sformatf("out_msg2_k%0d", k), 8'(if2.out_msg), 8'(exp_out(k, 2)));
        chk("out_last0", 8'(if0.out_last), 8'(k == DEG - 1));
        chk("out_last2", 8'(if2.out_last), 8'(k == DEG - 1));
        chk("emit_in_ready0", 8'(if0.in_ready), 8'd0);
    endtask

    task automatic send_frame();
        logic h = 1'b0;
        for (int i = 0; i < DEG; i++) begin
            @(negedge clk);
            drive(1'b1, msg[i], 1'b0);
            chk("in_ready0", 8'(if0.in_ready), 8'd1);
            chk("in_ready2", 8'(if2.in_ready), 8'd1);
            chk("collect_valid0", 8'(if0.out_valid), 8'd0);
            h ^= msg[i][5];
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        exp_par = ~h;
        chk("latency_valid0", 8'(if0.out_valid), 8'd1);
        chk("latency_valid2", 8'(if2.out_valid), 8'd1);
        chk("parity0", 8'(if0.parity_ok), 8'(exp_par));
        chk("parity2", 8'(if2.parity_ok), 8'(exp_par));
    endtask

    task automatic recv_frame(input int bp_k, input int abort_k);
        for (int k = 0; k < DEG; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                exp_par = 1'b0;
                check_idle("abort");
                chk("abort_msg0", 8'(if0.out_msg), 8'd0);
                chk("abort_last0", 8'(if0.out_last), 8'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == bp_k) begin
                repeat (3) begin
                    drive(1'b1, 6'($urandom), 1'b0);
                    check_out(k);
                    @(negedge clk);
                end
            end
            drive(1'b0, '0, 1'b1);
            check_out(k);
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        check_idle("post_frame");
    endtask

    initial begin
        drive(1'b0, '0, 1'b0);
        #12;
        check_idle("reset");
        chk("reset_msg0", 8'(if0.out_msg), 8'd0);
        chk("reset_last0", 8'(if0.out_last), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        load('{5, 3, 7, 3, 9, 4}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
        send_frame();
        recv_frame(-1, -1);

        load('{2, 8, 6, 10, 12, 15}, '{1, 0, 0, 0, 0, 1}, '{1, 0, 0, 0, 0, 0});
        send_frame();
        recv_frame(2, -1);

        load('{1, 4, 9, 9, 9, 9}, '{0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0});
        send_frame();
        recv_frame(-1, -1);

        load_rand();
        send_frame();
        recv_frame(-1, 3);
        send_frame();
        recv_frame(-1, -1);

        for (int f = 0; f < 20; f++) begin
            load_rand();
            send_frame();
            recv_frame((f % 3 == 0) ? int'($urandom_range(0, DEG - 1)) : -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
